bch73_decode_ctrl: RTL and testbench

//  Sequencer for the (73,37) syndrome/weight stage (s_gen). Accepts one 73-bit codeword (37 msg + 36 parity),

---
 rtl/bch73_decode_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bch73_decode_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch73_decode_ctrl.sv
// Error-trapping sequencer for an external (73,37) BCH syndrome stage; BCHCTL_STATS_EN adds block counters.
// Result 2 edges after accept plus 2 per rotation; one block in flight, in_ready only in IDLE, result held until out_ready.
module bch73_decode_ctrl #(
  parameter int MAX_ROT = 73,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [36:0]      in_m,
  input  logic [35:0]      in_p,
  output logic [36:0]      sg_m,
  output logic [35:0]      sg_p,
  input  logic [35:0]      sg_s,
  input  logic             sg_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [36:0]      out_m,
  output logic [1:0]       out_nerr,
  output logic             out_fail,
  output logic [CNT_W-1:0] stat_corr,
  output logic [CNT_W-1:0] stat_fail
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [72:0] cw_q, cw_d;
  logic [36:0] orig_m_q, orig_m_d;
  logic [6:0]  rot_cnt_q, rot_cnt_d;
  logic [36:0] out_m_q, out_m_d;
  logic [1:0]  nerr_q, nerr_d;
  logic        fail_q, fail_d;

  logic [5:0]  s_wt;
  logic [1:0]  s_nerr;
  logic [72:0] corr_w;
  logic [72:0] unrot_w;
  logic        last_rot;

  // Weight of the trapped syndrome; anything above 3 is clamped.
  always_comb begin
    s_wt = '0;
    for (int i = 0; i < 36; i++) begin
      s_wt = s_wt + {5'b0, sg_s[i]};
    end
    s_nerr = (s_wt > 6'd3) ? 2'd3 : s_wt[1:0];
  end

  // Correct in the rotated frame, then undo rot_cnt left rotations with a log-depth right rotator.
  always_comb begin
    corr_w  = cw_q ^ {37'b0, sg_s};
    unrot_w = corr_w;
    for (int i = 0; i < 7; i++) begin
      if (rot_cnt_q[i]) begin
        unrot_w = (unrot_w >> (1 << i)) | (unrot_w << (73 - (1 << i)));
      end
    end
  end

  assign last_rot = (rot_cnt_q == 7'(MAX_ROT - 1));

  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    orig_m_d  = orig_m_q;
    rot_cnt_d = rot_cnt_q;
    out_m_d   = out_m_q;
    nerr_d    = nerr_q;
    fail_d    = fail_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cw_d      = {in_m, in_p};
          orig_m_d  = in_m;
          rot_cnt_d = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (sg_flag) begin
          out_m_d = unrot_w[72:36];
          nerr_d  = s_nerr;
          fail_d  = 1'b0;
          state_d = S_DONE;
        end else if (last_rot) begin
          out_m_d = orig_m_q;
          nerr_d  = 2'd0;
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cw_d      = {cw_q[71:0], cw_q[72]};
          rot_cnt_d = rot_cnt_q + 7'd1;
          state_d   = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cw_q      <= '0;
      orig_m_q  <= '0;
      rot_cnt_q <= '0;
      out_m_q   <= '0;
      nerr_q    <= '0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      orig_m_q  <= orig_m_d;
      rot_cnt_q <= rot_cnt_d;
      out_m_q   <= out_m_d;
      nerr_q    <= nerr_d;
      fail_q    <= fail_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sg_m      = cw_q[72:36];
  assign sg_p      = cw_q[35:0];
  assign out_m     = out_m_q;
  assign out_nerr  = nerr_q;
  assign out_fail  = fail_q;

`ifdef BCHCTL_STATS_EN
  logic [CNT_W-1:0] stat_corr_q, stat_corr_d;
  logic [CNT_W-1:0] stat_fail_q, stat_fail_d;
  logic             done_hs;

  assign done_hs = (state_q == S_DONE) && out_ready;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_corr_d = stat_corr_q;
    stat_fail_d = stat_fail_q;
    if (done_hs) begin
      if ((nerr_q != 2'd0) && (stat_corr_q != '1)) begin
        stat_corr_d = stat_corr_q + 1'b1;
      end
      if (fail_q && (stat_fail_q != '1)) begin
        stat_fail_d = stat_fail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_corr_q <= '0;
      stat_fail_q <= '0;
    end else begin
      stat_corr_q <= stat_corr_d;
      stat_fail_q <= stat_fail_d;
    end
  end

  assign stat_corr = stat_corr_q;
  assign stat_fail = stat_fail_q;
`else
  assign stat_corr = '0;
  assign stat_fail = '0;
`endif

endmodule

// File: tb/tb_bch73_decode_ctrl.sv
// Directed bench for bch73_decode_ctrl with a behavioural (73,37) BCH syndrome stage (roots beta^1..beta^10, beta of order 73).
module tb_bch73_decode_ctrl;
  localparam int MAX_ROT = 73;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, out_valid, out_ready;
  logic [36:0]      in_m, sg_m, out_m;
  logic [35:0]      in_p, sg_p, sg_s;
  logic             sg_flag, out_fail;
  logic [1:0]       out_nerr;
  logic [CNT_W-1:0] stat_corr, stat_fail;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_corr = 0;
  int          exp_fail = 0;
  logic [36:0] g_poly;

  always #5 clk = ~clk;

  bch73_decode_ctrl #(.MAX_ROT(MAX_ROT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_p(in_p), .sg_m(sg_m), .sg_p(sg_p), .sg_s(sg_s), .sg_flag(sg_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_m(out_m), .out_nerr(out_nerr),
    .out_fail(out_fail), .stat_corr(stat_corr), .stat_fail(stat_fail)
  );

  function automatic logic [8:0] gf_mul(input logic [8:0] a, input logic [8:0] b);
    logic [17:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) if (b[i]) p = p ^ (18'(a) << i);
    for (int i = 17; i >= 9; i--) if (p[i]) p = p ^ (18'h211 << (i - 9));
    return p[8:0];
  endfunction

  function automatic logic [8:0] gf_pow(input logic [8:0] a, input int e);
    logic [8:0] r;
    r = 9'd1;
    for (int k = 0; k < e; k++) r = gf_mul(r, a);
    return r;
  endfunction

  // Minimal polynomial over GF(2) of beta^i, beta = alpha^7 in GF(512).
  function automatic logic [9:0] min_poly(input int i);
    logic [8:0] c [0:9];
    logic [8:0] beta, r;
    logic [9:0] mp;
    int         j, deg;
    beta = gf_pow(9'd2, 7);
    for (int k = 0; k < 10; k++) c[k] = '0;
    c[0] = 9'd1;
    deg  = 0;
    j    = i;
    do begin
      r = gf_pow(beta, j);
      for (int k = 9; k >= 1; k--) c[k] = c[k-1] ^ gf_mul(r, c[k]);
      c[0] = gf_mul(r, c[0]);
      deg++;
      j = (2 * j) % 73;
    end while (j != i && deg < 9);
    for (int k = 0; k < 10; k++) mp[k] = c[k][0];
    return mp;
  endfunction

  function automatic logic [36:0] gen_poly();
    logic [36:0] g, t;
    logic [9:0]  mp;
    int          roots [4];
    roots = '{1, 3, 5, 9};
    g = 37'd1;
    for (int q = 0; q < 4; q++) begin
      mp = min_poly(roots[q]);
      t  = '0;
      for (int k = 0; k < 10; k++) if (mp[k]) t = t ^ (g << k);
      g = t;
    end
    return g;
  endfunction

  function automatic logic [35:0] synd(input logic [72:0] w);
    logic [72:0] r;
    r = w;
    for (int i = 72; i >= 36; i--) if (r[i]) r = r ^ ({36'b0, g_poly} << (i - 36));
    return r[35:0];
  endfunction

  function automatic logic [35:0] enc(input logic [36:0] m);
    return synd({m, 36'b0});
  endfunction

  // External syndrome stage: registered, one cycle behind sg_m/sg_p.
  always @(posedge clk) begin
    sg_s    <= synd({sg_m, sg_p});
    sg_flag <= ($countones(synd({sg_m, sg_p})) <= 3);
  end

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic run_block(input string tag, input logic [36:0] m, input logic [35:0] p,
                           input logic [36:0] em, input logic [1:0] en, input logic ef, input int elat);
    int n;
    chk({tag, "_rdy"}, in_ready, 1'b1);
    in_m = m; in_p = p; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_cw"}, {sg_m, sg_p}, {m, p});
    chk({tag, "_busy"}, in_ready, 1'b0);
    wait_out(n);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_m"}, out_m, em);
    chk({tag, "_nerr"}, out_nerr, en);
    chk({tag, "_fail"}, out_fail, ef);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, out_valid, 1'b0);
    chk({tag, "_idle"}, in_ready, 1'b1);
`ifdef BCHCTL_STATS_EN
    if (en != 2'd0) exp_corr++;
    if (ef) exp_fail++;
`endif
    chk({tag, "_scorr"}, stat_corr, exp_corr);
    chk({tag, "_sfail"}, stat_fail, exp_fail);
  endtask

  initial begin
    logic [36:0] m1, m3, rx3, m4, rx4, m5, m6, m7;
    logic [35:0] p1, p3, p4, p5, p6, p7;
    logic [72:0] cw_rot;
    int          n;
    logic        seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_m = '0; in_p = '0;
    g_poly = gen_poly();
    m1 = 37'h1;
    p1 = enc(m1);
    cw_rot = {m1, p1};
    cw_rot = {cw_rot[71:0], cw_rot[72]};
    if (g_poly[36] !== 1'b1 || g_poly[0] !== 1'b1 || synd(cw_rot) !== 36'd0) begin
      $display("FAIL syndrome model not a cyclic (73,37) code g=%0h", g_poly);
      $fatal(1);
    end

    repeat (3) tick();
    chk("rst_hold_rdy", in_ready, 1'b1);
    reset = 1'b0;
    tick();
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_m", out_m, 37'd0);
    chk("rst_nerr", out_nerr, 2'd0);
    chk("rst_fail", out_fail, 1'b0);
    chk("rst_cw", {sg_m, sg_p}, 73'd0);
    chk("rst_scorr", stat_corr, 0);
    chk("rst_sfail", stat_fail, 0);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ordy_vld", out_valid, 1'b0);
    chk("idle_ordy_rdy", in_ready, 1'b1);

    run_block("clean", m1, p1, m1, 2'd0, 1'b0, 2);
    run_block("p5err", m1, p1 ^ 36'h20, m1, 2'd1, 1'b0, 2);

    m7 = 37'h0_dead_beef;
    p7 = enc(m7);
    run_block("m36err", m7 ^ 37'h10_0000_0000, p7, m7, 2'd1, 1'b0, 4);

    // Errors at cw bits 37,56,72 first sit inside the parity window after 36 left rotations.
    m3  = 37'h15_a5a5_a5a5;
    p3  = enc(m3);
    rx3 = m3 ^ 37'h10_0010_0002;
    run_block("tri", rx3, p3, m3, 2'd3, 1'b0, 2 + 2 * 36);

    m4  = 37'h0a_bcde_f012;
    p4  = enc(m4);
    rx4 = m4 ^ 37'hf;
    run_block("quad", rx4, p4, rx4, 2'd0, 1'b1, 2 * MAX_ROT);

    m5 = 37'h1f_ffff_ffff;
    p5 = enc(m5);
    m6 = 37'h12_3456_789a;
    p6 = enc(m6);
    in_m = m5; in_p = p5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("hold_lat", n, 2);
    in_m = m6; in_p = p6 ^ 36'h1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("hold%0d_vld", c), out_valid, 1'b1);
      chk($sformatf("hold%0d_m", c), out_m, m5);
      chk($sformatf("hold%0d_rdy", c), in_ready, 1'b0);
    end
    chk("hold_nerr", out_nerr, 2'd0);
    chk("hold_fail", out_fail, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_vld", out_valid, 1'b0);
    chk("rel_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("second_acc", in_ready, 1'b0);
    chk("second_cw", {sg_m, sg_p}, {m6, p6 ^ 36'h1});
    wait_out(n);
    chk("second_lat", n, 2);
    chk("second_m", out_m, m6);
    chk("second_nerr", out_nerr, 2'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`ifdef BCHCTL_STATS_EN
    exp_corr++;
`endif
    chk("second_scorr", stat_corr, exp_corr);

    in_m = rx4; in_p = p4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    chk("midrot_rdy", in_ready, 1'b0);
    chk("midrot_vld", out_valid, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_corr = 0;
    exp_fail = 0;
    chk("abort_rdy", in_ready, 1'b1);
    chk("abort_vld", out_valid, 1'b0);
    chk("abort_m", out_m, 37'd0);
    chk("abort_cw", {sg_m, sg_p}, 73'd0);
    chk("abort_scorr", stat_corr, exp_corr);
    chk("abort_sfail", stat_fail, exp_fail);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_out", seen, 1'b0);
    run_block("recover", m1, p1 ^ 36'h800000000, m1, 2'd1, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
